// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one request per mem_req assertion,
// performs a byte-enabled write or a full-word read, and flags illegal accesses.
module dmem_responder #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_byteen,
  input  logic              mem_we,
  input  logic              mem_req,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  output logic              mem_err,
  output logic              busy,
  output logic [15:0]       txn_count,
  output logic [15:0]       err_count
);

  localparam int            AW   = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] SPAN = (XLEN+1)'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, ACCEPT, HOLD} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] ram [DEPTH_WORDS];
  logic [XLEN-1:0] offset;
  logic [AW-1:0]   word_idx;
  logic            in_range, be_legal, req_err;
  logic            accept, do_write;
  logic            err_q;

  assign offset   = mem_addr - BASE_ADDR;
  assign in_range = (mem_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign word_idx = offset[AW+1:2];

  always_comb begin
    case (mem_byteen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
      default:                   be_legal = 1'b0;
    endcase
  end

  assign req_err  = !in_range || (mem_addr[1:0] != 2'b00) || !be_legal;
  assign accept   = (state == IDLE) && mem_req;
  assign do_write = accept && mem_we && !req_err;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_req)  state_nxt = ACCEPT;
      ACCEPT:  state_nxt = mem_req ? HOLD : IDLE;
      HOLD:    if (!mem_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The whole transaction is resolved on the accept edge; later input changes are never looked at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= '0;
      err_q     <= 1'b0;
      txn_count <= '0;
      err_count <= '0;
    end else if (accept) begin
      mem_rdata <= (!mem_we && !req_err) ? ram[word_idx] : '0;
      err_q     <= req_err;
      if (txn_count != 16'hFFFF)            txn_count <= txn_count + 16'd1;
      if (req_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

  // NOTE: the RAM has no reset so it maps onto block memory; rst_n only gates writes so a
  // request pending during reset is never committed.
  always_ff @(posedge clk) begin
    if (rst_n && do_write) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (mem_byteen[b]) ram[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign busy    = (state != IDLE);
  assign mem_err = err_q && busy;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/address width; only 32 is supported.
REQ-002 Parameter DEPTH_WORDS, default 1024, SHALL set RAM size in words (power of two).
REQ-003 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 mem_addr  in  XLEN  byte address from the initiator (word aligned by contract).
REQ-007 mem_byteen  in  XLEN/8  byte lane enables, bit i = bits [8i+7:8i].
REQ-008 mem_we  in  1  1 = write, 0 = read.
REQ-009 mem_req  in  1  request; held high for at least 2 cycles per transaction.
REQ-010 mem_wdata  in  XLEN  lane-aligned write data.
REQ-011 mem_rdata  out  XLEN  full read word (initiator does lane extraction and sign extension).
REQ-012 mem_err  out  1  transaction error flag.
REQ-013 busy  out  1  high while a transaction is in progress (ACCEPT or HOLD).
REQ-014 txn_count  out  16  saturating count of accepted transactions, errors included.
REQ-015 err_count  out  16  saturating count of errored transactions.

Function
REQ-016 The FSM SHALL have states IDLE, ACCEPT, HOLD.
REQ-017 IDLE: a transaction SHALL start when mem_req=1; the next state SHALL be ACCEPT. Otherwise the FSM SHALL stay in IDLE.
REQ-018 On the IDLE->ACCEPT edge the block SHALL latch addr, byteen, we and wdata, evaluate errors, and, for a legal write, commit the enabled bytes to RAM; each write SHALL be committed exactly once.
REQ-019 On the same edge, for a legal read, mem_rdata SHALL be registered with RAM[word index]; mem_rdata and mem_err SHALL therefore be valid in the cycle after mem_req first rises (the initiator's second req cycle).
REQ-020 ACCEPT: the next state SHALL be HOLD if mem_req=1, otherwise IDLE.
REQ-021 HOLD: the block SHALL stay in HOLD while mem_req=1 and return to IDLE when mem_req=0; mem_rdata and mem_err SHALL stay stable; input changes during ACCEPT/HOLD SHALL be ignored (no re-execution).
REQ-022 Error if any of: addr < BASE_ADDR; addr >= BASE_ADDR + DEPTH_WORDS*4; addr[1:0] != 0; byteen not in {0001,0010,0100,1000,0011,1100,1111}.
REQ-023 On error: no RAM write; mem_rdata=0; mem_err=1 in ACCEPT/HOLD; err_count increments.
REQ-024 Word index SHALL be (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
REQ-025 A legal write SHALL drive mem_rdata=0; a legal read SHALL return all 4 bytes regardless of byteen.
REQ-026 mem_err SHALL be 0 in IDLE. mem_rdata SHALL keep its last value in IDLE.
REQ-027 Back-to-back: a new transaction SHALL be accepted in the first IDLE cycle in which mem_req=1, including the cycle directly after HOLD->IDLE.
REQ-028 A read immediately after a write to the same word SHALL return the newly written data (the write is committed before the next accept).
REQ-029 txn_count and err_count SHALL increment on the IDLE->ACCEPT edge and saturate at 16'hFFFF.
REQ-030 busy SHALL be 1 in ACCEPT and HOLD, 0 in IDLE.

Reset
REQ-031 Asserting rst_n=0 SHALL force state=IDLE, mem_rdata=0, mem_err=0, busy=0, txn_count=0, err_count=0 asynchronously.
REQ-032 RAM contents SHALL NOT be reset; a write whose accept edge has not occurred when reset asserts SHALL NOT be committed.
REQ-033 After reset release, a req already high SHALL be treated as a new transaction on the first clk edge.

Verification
REQ-034 SW-then-LW: write addr 0x10, byteen 1111, wdata 0xDEADBEEF; then read 0x10 -> mem_rdata=0xDEADBEEF in the 2nd req cycle, mem_err=0, txn_count=2.
REQ-035 Partial write: pre-load 0x11223344 at 0x20, write byteen 0100 wdata 0x00AA0000 -> read returns 0x11AA3344; byteen 1100 wdata 0xBEEF0000 -> read returns 0xBEEF3344.
REQ-036 Errors: read 0x1000 (DEPTH_WORDS=1024) -> mem_err=1, rdata=0; write 0x22 -> mem_err=1, no RAM change; byteen 0110 -> mem_err=1; err_count=3.
REQ-037 Long req: hold mem_req for 5 cycles on a write of 0x1 to 0x30 while changing wdata after cycle 1 -> RAM[0x30]=0x1, a single txn_count increment, and the FSM in HOLD until req drops.
REQ-038 Reset mid-op: assert rst_n in ACCEPT -> outputs and counters 0 immediately; release with req low -> IDLE, and the next read succeeds.
REQ-039 Counter saturation: force 65536+ transactions (or preload) -> txn_count stays 16'hFFFF.
